// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational integer ALU between the execute
// stage (requester 0) and the branch/address-compare path (requester 1).
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,

    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [DATA_WIDTH-1:0]     req0_src_a,
    input  logic [DATA_WIDTH-1:0]     req0_src_b,
    input  logic [ALU_CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [DATA_WIDTH-1:0]     req0_pc,

    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [DATA_WIDTH-1:0]     req1_src_a,
    input  logic [DATA_WIDTH-1:0]     req1_src_b,
    input  logic [ALU_CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [DATA_WIDTH-1:0]     req1_pc,

    output logic [DATA_WIDTH-1:0]     alu_src_a,
    output logic [DATA_WIDTH-1:0]     alu_src_b,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
    output logic [DATA_WIDTH-1:0]     alu_pc,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_n,
    input  logic                      alu_c,
    input  logic                      alu_v,

    output logic [1:0]                rsp_valid,
    input  logic [1:0]                rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_n,
    output logic                      rsp_c,
    output logic                      rsp_v
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic                    last_grant, last_grant_nxt;
    logic [1:0]              rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   rsp_result_nxt;
    logic                    rsp_zero_nxt, rsp_n_nxt, rsp_c_nxt, rsp_v_nxt;

    logic                    rsp_hs;
    logic                    issue_ok;
    logic                    grant_any;
    logic                    grant_sel;

    assign rsp_hs    = |(rsp_valid & rsp_ready);
    assign issue_ok  = !rst && !flush && ((state == IDLE) || rsp_hs);
    assign grant_any = req0_valid || req1_valid;
    // On contention the requester not granted last time wins.
    assign grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    // Next-state, grant and ALU-port steering.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        rsp_valid_nxt  = rsp_valid;
        rsp_result_nxt = rsp_result;
        rsp_zero_nxt   = rsp_zero;
        rsp_n_nxt      = rsp_n;
        rsp_c_nxt      = rsp_c;
        rsp_v_nxt      = rsp_v;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        alu_src_a      = '0;
        alu_src_b      = '0;
        alu_ctrl       = '0;
        alu_pc         = '0;

        if (issue_ok && grant_any) begin
            if (grant_sel) begin
                req1_ready    = 1'b1;
                alu_src_a     = req1_src_a;
                alu_src_b     = req1_src_b;
                alu_ctrl      = req1_ctrl;
                alu_pc        = req1_pc;
                rsp_valid_nxt = 2'b10;
            end else begin
                req0_ready    = 1'b1;
                alu_src_a     = req0_src_a;
                alu_src_b     = req0_src_b;
                alu_ctrl      = req0_ctrl;
                alu_pc        = req0_pc;
                rsp_valid_nxt = 2'b01;
            end
            last_grant_nxt = grant_sel;
            rsp_result_nxt = alu_result;
            rsp_zero_nxt   = alu_zero;
            rsp_n_nxt      = alu_n;
            rsp_c_nxt      = alu_c;
            rsp_v_nxt      = alu_v;
            state_nxt      = RESP;
        end else if (flush || rsp_hs) begin
            rsp_valid_nxt = 2'b00;
            state_nxt     = IDLE;
        end
    end

    // State and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_n      <= 1'b0;
            rsp_c      <= 1'b0;
            rsp_v      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_result <= rsp_result_nxt;
            rsp_zero   <= rsp_zero_nxt;
            rsp_n      <= rsp_n_nxt;
            rsp_c      <= rsp_c_nxt;
            rsp_v      <= rsp_v_nxt;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a stand-in ALU, a transaction-level
// arbitration model pushing expected responses, and a monitor popping them.
module tb_alu_share_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_src_a, req0_src_b, req0_pc, req1_src_a, req1_src_b, req1_pc;
    logic [CW-1:0] req0_ctrl, req1_ctrl;
    logic [DW-1:0] alu_src_a, alu_src_b, alu_pc, alu_result;
    logic [CW-1:0] alu_ctrl;
    logic          alu_zero, alu_n, alu_c, alu_v;
    logic [1:0]    rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero, rsp_n, rsp_c, rsp_v;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          id;
        logic [35:0] val;
    } exp_t;
    exp_t exp_q[$];
    int   model_last = 1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src_a(req0_src_a),
        .req0_src_b(req0_src_b), .req0_ctrl(req0_ctrl), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src_a(req1_src_a),
        .req1_src_b(req1_src_b), .req1_ctrl(req1_ctrl), .req1_pc(req1_pc),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .alu_pc(alu_pc),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_n(rsp_n), .rsp_c(rsp_c), .rsp_v(rsp_v)
    );

    // Returns {zero, n, c, v, result}.
    function automatic logic [35:0] alu_fn(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc);
        logic [32:0] s;
        logic [31:0] r;
        logic        cf, vf;
        cf = 1'b0;
        vf = 1'b0;
        s  = '0;
        case (c)
            4'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cf = s[32];
                vf = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                cf = s[32];
                vf = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = pc + b;
        endcase
        return {(r == 32'd0), r[31], cf, vf, r};
    endfunction

    assign {alu_zero, alu_n, alu_c, alu_v, alu_result} = alu_fn(alu_ctrl, alu_src_a, alu_src_b, alu_pc);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever response is presented with the queue head.
    always @(negedge clk) begin
        #1;
        if (rst !== 1'b1) begin
            if (rsp_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("rsp_valid_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    check("rsp_valid", 64'(rsp_valid), (exp_q[0].id == 1) ? 64'd2 : 64'd1);
                    check("rsp_result", 64'(rsp_result), 64'(exp_q[0].val[31:0]));
                    check("rsp_flags", 64'({rsp_zero, rsp_n, rsp_c, rsp_v}), 64'(exp_q[0].val[35:32]));
                    if (((rsp_valid & rsp_ready) != 2'b00) || flush)
                        void'(exp_q.pop_front());
                end
            end else if (exp_q.size() != 0) begin
                check("rsp_valid_missing", 64'(rsp_valid), (exp_q[0].id == 1) ? 64'd2 : 64'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; the arbitration model runs after the monitor has retired
    // this cycle's completed or flushed response.
    task automatic step(input logic rs, input logic fl, input logic [1:0] rr,
                        input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1);
        int win;
        @(negedge clk);
        rst = rs; flush = fl; rsp_ready = rr;
        req0_valid = v0; req0_ctrl = c0; req0_src_a = a0; req0_src_b = b0; req0_pc = $urandom;
        req1_valid = v1; req1_ctrl = c1; req1_src_a = a1; req1_src_b = b1; req1_pc = $urandom;
        #3;
        win = -1;
        if (rs) begin
            exp_q.delete();
            model_last = 1;
        end else if (!fl && exp_q.size() == 0) begin
            if (v0 && v1) win = (model_last == 1) ? 0 : 1;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
        end
        check("req0_ready", 64'(req0_ready), 64'(win == 0));
        check("req1_ready", 64'(req1_ready), 64'(win == 1));
        if (win < 0 && !rs)
            check("alu_ports_idle", {32'(alu_src_a | alu_src_b | alu_pc), 32'(alu_ctrl)}, 64'd0);
        if (win == 0) exp_q.push_back('{id: 0, val: alu_fn(c0, a0, b0, req0_pc)});
        if (win == 1) exp_q.push_back('{id: 1, val: alu_fn(c1, a1, b1, req1_pc)});
        if (win >= 0) model_last = win;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] rr);
        step(1'b0, 1'b0, rr, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rsp_ready = 2'b00;
        req0_valid = 1'b0; req0_ctrl = '0; req0_src_a = '0; req0_src_b = '0; req0_pc = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_src_a = '0; req1_src_b = '0; req1_pc = '0;

        // Reset with both requesters asking: no grants, outputs cleared.
        step(1'b1, 1'b0, 2'b11, 1'b1, 4'd0, 32'd1, 32'd2, 1'b1, 4'd0, 32'd3, 32'd4);
        step(1'b1, 1'b0, 2'b11, 1'b1, 4'd0, 32'd1, 32'd2, 1'b1, 4'd0, 32'd3, 32'd4);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_result", 64'(rsp_result), 64'd0);
        check("reset_rsp_flags", 64'({rsp_zero, rsp_n, rsp_c, rsp_v}), 64'd0);

        // Single add 5 + 7.
        step(1'b0, 1'b0, 2'b11, 1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0);
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_result", 64'(rsp_result), 64'd12);
        check("single_zero", 64'(rsp_zero), 64'd0);
        idle(2'b11);

        // Contention with always-ready consumers.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 2'b11, 1'b1, 4'($urandom_range(0, 6)), $urandom, $urandom,
                 1'b1, 4'($urandom_range(0, 6)), $urandom, $urandom);
        idle(2'b11);

        // Backpressure on a req1 subtract 9 - 9 while req0 waits.
        step(1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 32'd9, 32'd9);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'b00, 1'b1, 4'd3, 32'hF0, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0);
            check("bp_valid", 64'(rsp_valid), 64'd2);
            check("bp_result", 64'(rsp_result), 64'd0);
            check("bp_zero", 64'(rsp_zero), 64'd1);
        end
        step(1'b0, 1'b0, 2'b10, 1'b1, 4'd3, 32'hF0, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0);
        check("bp_issue_result", 64'(rsp_result), 64'hFF);
        idle(2'b11);

        // Flag pass-through.
        step(1'b0, 1'b0, 2'b11, 1'b1, 4'd0, 32'h7FFFFFFF, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
        check("ovf_result", 64'(rsp_result), 64'h80000000);
        check("ovf_flags", 64'({rsp_zero, rsp_n, rsp_c, rsp_v}), 64'b0101);
        step(1'b0, 1'b0, 2'b11, 1'b1, 4'd0, 32'hFFFFFFFF, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0);
        check("carry_result", 64'(rsp_result), 64'd0);
        check("carry_flags", 64'({rsp_zero, rsp_n, rsp_c, rsp_v}), 64'b1010);
        idle(2'b11);

        // Flush a held req0 response while req1 is waiting.
        step(1'b0, 1'b0, 2'b00, 1'b1, 4'd2, 32'hFF, 32'h3C, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd4, 32'hA5, 32'h5A);
        check("flush_valid", 64'(rsp_valid), 64'd0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd4, 32'hA5, 32'h5A);
        check("post_flush_grant", 64'(rsp_valid), 64'd2);
        idle(2'b11);

        // Reset mid-response, then contention goes to req0 first.
        step(1'b0, 1'b0, 2'b00, 1'b1, 4'd0, 32'd40, 32'd2, 1'b0, 4'd0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 4'd0, 32'd2, 32'd2);
        check("rst_mid_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_result", 64'(rsp_result), 64'd0);
        step(1'b0, 1'b0, 2'b11, 1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 4'd0, 32'd2, 32'd2);
        check("rst_first_winner", 64'(rsp_valid), 64'd1);
        idle(2'b11);

        // Randomized traffic with backpressure, flushes and rare resets.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), 2'($urandom),
                 1'($urandom), 4'($urandom_range(0, 7)), $urandom, $urandom,
                 1'($urandom), 4'($urandom_range(0, 7)), $urandom, $urandom);
        idle(2'b11);
        idle(2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
